// File: rtl/uart_bus_master.sv
// UART-driven word read/write initiator for the CPU memory bus (debug / boot loader).
// Frames: cmd, addr[4] LSB first, and for 'W' data[4] LSB first; replies go back over the uart TX side.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    input  logic        rx_error,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        cpu_hold,
    output logic [3:0]  dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ADDR    = 4'd1,
        S_DATA    = 4'd2,
        S_MEM_WR  = 4'd3,
        S_WR_WAIT = 4'd4,
        S_MEM_RD  = 4'd5,
        S_RD_WAIT = 4'd6,
        S_TX      = 4'd7,
        S_TX_WAIT = 4'd8
    } state_t;

    state_t        state_q;
    logic [1:0]    cnt_q;
    logic [1:0]    tx_last_q;
    logic [TW-1:0] tmo_q;
    logic          is_wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   tx_buf_q;
    logic          rx_ack_q;
    logic          rx_skip_q;
    logic [7:0]    tx_data_q;
    logic          tx_wr_q;
    logic [3:0]    mem_wmask_q;
    logic          mem_rstrb_q;
    logic          cpu_hold_q;

    logic intake_state;
    logic rx_take;
    logic [4:0] byte_sel;

    // The uart drops rx_avail one cycle after seeing rx_ack, so both the ack cycle
    // and the one after it must not be mistaken for a fresh byte.
    assign intake_state = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign rx_take      = rx_avail && !rx_ack_q && !rx_skip_q && intake_state;
    assign byte_sel     = {cnt_q, 3'b000};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            tx_last_q   <= 2'd0;
            tmo_q       <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            tx_buf_q    <= 32'd0;
            rx_ack_q    <= 1'b0;
            rx_skip_q   <= 1'b0;
            tx_data_q   <= 8'd0;
            tx_wr_q     <= 1'b0;
            mem_wmask_q <= 4'd0;
            mem_rstrb_q <= 1'b0;
            cpu_hold_q  <= 1'b0;
        end else begin
            rx_ack_q    <= 1'b0;
            rx_skip_q   <= rx_ack_q;
            tx_wr_q     <= 1'b0;
            mem_wmask_q <= 4'd0;
            mem_rstrb_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    tmo_q <= '0;
                    if (rx_take) begin
                        rx_ack_q <= 1'b1;
                        cnt_q    <= 2'd0;
                        if (rx_error) begin
                            state_q <= S_IDLE;
                        end else if (rx_data == CMD_W || rx_data == CMD_R) begin
                            is_wr_q    <= (rx_data == CMD_W);
                            cpu_hold_q <= 1'b1;
                            state_q    <= S_ADDR;
                        end else begin
                            tx_buf_q  <= {24'd0, NAK_BYTE};
                            tx_last_q <= 2'd0;
                            state_q   <= S_TX;
                        end
                    end
                end

                S_ADDR, S_DATA: begin
                    if (rx_take) begin
                        rx_ack_q <= 1'b1;
                        tmo_q    <= '0;
                        if (rx_error) begin
                            cpu_hold_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                            if (state_q == S_ADDR) begin
                                addr_q[byte_sel +: 8] <= rx_data;
                            end else begin
                                wdata_q[byte_sel +: 8] <= rx_data;
                            end
                            if (cnt_q == 2'd3) begin
                                if (state_q == S_DATA) begin
                                    mem_wmask_q <= 4'hF;
                                    state_q     <= S_MEM_WR;
                                end else if (is_wr_q) begin
                                    state_q <= S_DATA;
                                end else begin
                                    mem_rstrb_q <= 1'b1;
                                    state_q     <= S_MEM_RD;
                                end
                            end
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Stalled host: drop the partial frame silently and free the bus.
                        tmo_q      <= '0;
                        cpu_hold_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end

                S_MEM_WR: state_q <= S_WR_WAIT;

                S_WR_WAIT: begin
                    if (!mem_wbusy) begin
                        tx_buf_q  <= {24'd0, ACK_BYTE};
                        tx_last_q <= 2'd0;
                        cnt_q     <= 2'd0;
                        state_q   <= S_TX;
                    end
                end

                S_MEM_RD: state_q <= S_RD_WAIT;

                S_RD_WAIT: begin
                    if (!mem_rbusy) begin
                        tx_buf_q  <= mem_rdata;
                        tx_last_q <= 2'd3;
                        cnt_q     <= 2'd0;
                        state_q   <= S_TX;
                    end
                end

                S_TX: begin
                    if (!tx_busy) begin
                        tx_data_q <= tx_buf_q[byte_sel +: 8];
                        tx_wr_q   <= 1'b1;
                        state_q   <= S_TX_WAIT;
                    end
                end

                S_TX_WAIT: begin
                    // tx_wr_q is still high in the first cycle here; tx_busy is not valid yet.
                    if (!tx_wr_q && !tx_busy) begin
                        if (cnt_q == tx_last_q) begin
                            cpu_hold_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                            state_q <= S_TX;
                        end
                    end
                end

                default: begin
                    cpu_hold_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ack    = rx_ack_q;
    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign mem_addr  = addr_q & 32'hFFFF_FFFC;
    assign mem_wdata = wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign mem_rstrb = mem_rstrb_q;
    assign cpu_hold  = cpu_hold_q;
    assign dbg_state = state_q;

endmodule
